// File: rtl/latch_deserializer.sv
// Packs the serial latch output into WIDTH-bit words behind a valid/ready buffer with one-word stall holding.
// Optional even-parity frame bit and o_parity_err output are enabled by defining DESER_PARITY_EN.
module latch_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_d,
  input  logic             i_d_valid,
  output logic [WIDTH-1:0] o_word,
  output logic             o_word_valid,
  input  logic             i_word_ready,
  output logic             o_overrun,
  input  logic             i_clear_ovr,
`ifdef DESER_PARITY_EN
  output logic             o_parity_err,
`endif
  output logic             o_busy
);

`ifdef DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic {S_COLLECT, S_STALL} state_t;

  state_t           r_state, w_next_state;
  logic [WIDTH-1:0] r_shift, w_next_shift;
  logic [CW-1:0]    r_count, w_next_count;
  logic [WIDTH-1:0] r_word, w_next_word;
  logic             r_valid, w_next_valid;
  logic             r_ovr, w_next_ovr;
  logic             w_drop;
  logic             w_xfer;
  logic             w_free;
  logic             w_data_bit;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] w_assembled;

  assign w_xfer    = r_valid && i_word_ready;
  assign w_free    = !r_valid || i_word_ready;
  assign w_shifted = MSB_FIRST ? {r_shift[WIDTH-2:0], i_d} : {i_d, r_shift[WIDTH-1:1]};

`ifdef DESER_PARITY_EN
  logic r_par, w_next_par;
  logic r_perr, w_next_perr;
  logic r_held_perr, w_next_held_perr;
  logic w_perr_calc;

  // The parity bit never enters the shift register, so the word is already complete.
  assign w_data_bit  = (r_count != LAST);
  assign w_assembled = r_shift;
  assign w_perr_calc = r_par ^ i_d;
`else
  assign w_data_bit  = 1'b1;
  assign w_assembled = w_shifted;
`endif

  always_comb begin
    w_next_state = r_state;
    w_next_shift = r_shift;
    w_next_count = r_count;
    w_next_word  = r_word;
    w_next_valid = r_valid;
    w_next_ovr   = r_ovr;
    w_drop       = 1'b0;
`ifdef DESER_PARITY_EN
    w_next_par       = r_par;
    w_next_perr      = r_perr;
    w_next_held_perr = r_held_perr;
`endif
    if (w_xfer) w_next_valid = 1'b0;

    case (r_state)
      S_COLLECT: begin
        if (i_d_valid) begin
          if (w_data_bit) begin
            w_next_shift = w_shifted;
`ifdef DESER_PARITY_EN
            w_next_par = r_par ^ i_d;
`endif
          end
          if (r_count == LAST) begin
            w_next_count = '0;
`ifdef DESER_PARITY_EN
            w_next_par = 1'b0;
`endif
            if (w_free) begin
              w_next_word  = w_assembled;
              w_next_valid = 1'b1;
`ifdef DESER_PARITY_EN
              w_next_perr = w_perr_calc;
`endif
            end else begin
              // Completed word waits in the shift register until the buffer drains.
              w_next_state = S_STALL;
`ifdef DESER_PARITY_EN
              w_next_held_perr = w_perr_calc;
`endif
            end
          end else begin
            w_next_count = r_count + 1'b1;
          end
        end
      end
      S_STALL: begin
        w_drop = i_d_valid;
        if (w_xfer) begin
          w_next_word  = r_shift;
          w_next_valid = 1'b1;
          w_next_state = S_COLLECT;
`ifdef DESER_PARITY_EN
          w_next_perr = r_held_perr;
`endif
        end
      end
      default: w_next_state = S_COLLECT;
    endcase

    if (w_drop) w_next_ovr = 1'b1;
    else if (i_clear_ovr) w_next_ovr = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_COLLECT;
      r_shift <= '0;
      r_count <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef DESER_PARITY_EN
      r_par       <= 1'b0;
      r_perr      <= 1'b0;
      r_held_perr <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      r_shift <= w_next_shift;
      r_count <= w_next_count;
      r_word  <= w_next_word;
      r_valid <= w_next_valid;
      r_ovr   <= w_next_ovr;
`ifdef DESER_PARITY_EN
      r_par       <= w_next_par;
      r_perr      <= w_next_perr;
      r_held_perr <= w_next_held_perr;
`endif
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_valid;
  assign o_overrun    = r_ovr;
  assign o_busy       = (r_count != '0) || (r_state == S_STALL);
`ifdef DESER_PARITY_EN
  assign o_parity_err = r_perr;
`endif

endmodule

// File: tb/tb_latch_deserializer.sv
// Scoreboard bench for latch_deserializer: two instances (MSB-first and LSB-first) share one stimulus stream
// and are checked against a frame-level reference model; define DESER_PARITY_EN to exercise the parity frame bit.
module tb_latch_deserializer;

   localparam int WIDTH = 8;
`ifdef DESER_PARITY_EN
   localparam int FRAME = WIDTH + 1;
`else
   localparam int FRAME = WIDTH;
`endif

   logic clk = 1'b0;
   logic rst;
   logic d;
   logic dValid;
   logic wordReady;
   logic clearOvr;
   logic [WIDTH-1:0] wordM, wordL;
   logic validM, validL, ovrM, ovrL, busyM, busyL;
`ifdef DESER_PARITY_EN
   logic perrM, perrL;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [WIDTH-1:0] wM;
      logic [WIDTH-1:0] wL;
      bit perr;
   } exp_t;

   exp_t sb[$];
   bit frameBits[$];
   int occ = 0;
   bit expOvr = 1'b0;

   latch_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dutM (
      .i_clk(clk), .i_rst(rst), .i_d(d), .i_d_valid(dValid),
      .o_word(wordM), .o_word_valid(validM), .i_word_ready(wordReady),
      .o_overrun(ovrM), .i_clear_ovr(clearOvr),
`ifdef DESER_PARITY_EN
      .o_parity_err(perrM),
`endif
      .o_busy(busyM));

   latch_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) dutL (
      .i_clk(clk), .i_rst(rst), .i_d(d), .i_d_valid(dValid),
      .o_word(wordL), .o_word_valid(validL), .i_word_ready(wordReady),
      .o_overrun(ovrL), .i_clear_ovr(clearOvr),
`ifdef DESER_PARITY_EN
      .o_parity_err(perrL),
`endif
      .o_busy(busyL));

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame-level reference: the DUT holds up to two words (output buffer plus one stalled word);
   // while both are occupied incoming bits are lost and flag an overrun.
   task automatic modelEdge(input bit bitIn, input bit dv, input bit rdy, input bit clr);
      bit stalled;
      bit drain;
      bit drop;
      exp_t e;
      stalled = (occ == 2);
      drain   = (occ > 0) && rdy;
      drop    = 1'b0;
      if (dv) begin
         if (stalled) begin
            drop = 1'b1;
         end else begin
            frameBits.push_back(bitIn);
            if (frameBits.size() == FRAME) begin
               e.wM = '0;
               e.wL = '0;
               e.perr = 1'b0;
               for (int i = 0; i < WIDTH; i++) begin
                  e.wM[WIDTH-1-i] = frameBits[i];
                  e.wL[i] = frameBits[i];
               end
               for (int i = 0; i < FRAME; i++) e.perr ^= frameBits[i];
               sb.push_back(e);
               frameBits.delete();
               occ++;
            end
         end
      end
      if (drain) occ--;
      if (drop) expOvr = 1'b1;
      else if (clr) expOvr = 1'b0;
   endtask

   // Drive one clock edge worth of inputs, then advance the model past that edge.
   task automatic applyStimulus(input bit bitIn, input bit dv, input bit rdy, input bit clr);
      d = bitIn;
      dValid = dv;
      wordReady = rdy;
      clearOvr = clr;
      @(posedge clk);
      modelEdge(bitIn, dv, rdy, clr);
      #2;
   endtask

   // Send one frame MSB of w first, optional parity bit last, with random idle gaps.
   task automatic sendWord(input logic [WIDTH-1:0] w, input bit parBit, input int gapMax, input bit rdy);
      for (int i = 0; i < FRAME; i++) begin
         if (i > 0 && gapMax > 0) begin
            int g;
            g = $urandom_range(gapMax, 1);
            for (int k = 0; k < g; k++) applyStimulus(1'b0, 1'b0, rdy, 1'b0);
         end
         if (i < WIDTH) applyStimulus(w[WIDTH-1-i], 1'b1, rdy, 1'b0);
         else applyStimulus(parBit, 1'b1, rdy, 1'b0);
      end
   endtask

   // Monitor: compares handshake state every cycle and pops the scoreboard on each transfer.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            checkOutput("valid_msb", {31'b0, validM}, {31'b0, occ > 0});
            checkOutput("valid_lsb", {31'b0, validL}, {31'b0, occ > 0});
            checkOutput("overrun", {30'b0, ovrM, ovrL}, {30'b0, expOvr, expOvr});
            checkOutput("busy", {30'b0, busyM, busyL},
                        {30'b0, {2{(frameBits.size() != 0) || (occ == 2)}}});
            if (validM && wordReady) begin
               if (sb.size() == 0) begin
                  checkOutput("sb_underflow", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  checkOutput("word_msb", 32'(wordM), 32'(e.wM));
                  checkOutput("word_lsb", 32'(wordL), 32'(e.wL));
`ifdef DESER_PARITY_EN
                  checkOutput("parity_err", {30'b0, perrM, perrL}, {30'b0, e.perr, e.perr});
`endif
               end
            end
         end
      end
   end

   // Watchdog so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      d = 1'b0;
      dValid = 1'b0;
      wordReady = 1'b0;
      clearOvr = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      checkOutput("reset_word", 32'(wordM), 32'd0);
      rst = 1'b0;

      // Contiguous frame, ready held high.
      sendWord(8'hB2, 1'b0, 0, 1'b1);
      checkOutput("dir_msb_B2", 32'(wordM), 32'hB2);
      checkOutput("dir_lsb_4D", 32'(wordL), 32'h4D);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("dir_valid_drop", {31'b0, validM}, 32'd0);

      // Same frame with idle gaps between bits.
      sendWord(8'hB2, 1'b0, 3, 1'b1);
      checkOutput("gap_msb_B2", 32'(wordM), 32'hB2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

      // Back-pressure: second word stalls, extra bits are dropped.
      sendWord(8'hB2, 1'b0, 0, 1'b0);
      sendWord(8'h5A, 1'b0, 0, 1'b0);
      checkOutput("stall_hold_B2", 32'(wordM), 32'hB2);
      checkOutput("stall_busy", {31'b0, busyM}, 32'd1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("stall_overrun", {31'b0, ovrM}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("release_5A", 32'(wordM), 32'h5A);
      checkOutput("release_valid", {31'b0, validM}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("clear_ovr", {31'b0, ovrM}, 32'd0);

      // Asynchronous reset in the middle of a frame.
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      sendWord(8'h3C, 1'b0, 0, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("async_word", 32'(wordM), 32'd0);
      checkOutput("async_valid", {31'b0, validM}, 32'd0);
      checkOutput("async_busy", {31'b0, busyM}, 32'd0);
      sb.delete();
      frameBits.delete();
      occ = 0;
      expOvr = 1'b0;
      #1;
      rst = 1'b0;
      sendWord(8'hB2, 1'b0, 0, 1'b1);
      checkOutput("post_reset_B2", 32'(wordM), 32'hB2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

`ifdef DESER_PARITY_EN
      sendWord(8'hB2, 1'b0, 0, 1'b1);
      checkOutput("parity_ok", {31'b0, perrM}, 32'd0);
      checkOutput("parity_ok_word", 32'(wordM), 32'hB2);
      sendWord(8'hB2, 1'b1, 0, 1'b1);
      checkOutput("parity_bad", {31'b0, perrM}, 32'd1);
      checkOutput("parity_bad_word", 32'(wordM), 32'hB2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
`endif

      // Randomized traffic with bursts of back-pressure and overrun clears.
      for (int i = 0; i < 600; i++) begin
         applyStimulus(1'($urandom_range(1, 0)),
                       $urandom_range(9, 0) < 6,
                       $urandom_range(9, 0) < 5,
                       $urandom_range(9, 0) == 0);
      end

      // Drain everything that is left.
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkOutput("sb_empty", 32'(sb.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/latch_deserializer.md
Name: latch_deserializer

Overview:
- Consumes the serial bit stream from the d_latch output stage (q, one bit per d_valid strobe) and packs it into WIDTH-bit parallel words.
- Presents each word on a valid/ready interface with a one-word output buffer and one-word stall holding.
- Flags dropped input bits with a sticky overrun flag.
- Sits directly downstream of the latch stage and feeds the word-level logic.

Parameters:
- WIDTH, 8, bits per word; valid range 2..32.
- MSB_FIRST, 1, 1: first received bit lands in word[WIDTH-1]; 0: first received bit lands in word[0].

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- d  in  1  serial data bit (latch q).
- d_valid  in  1  d is sampled on a clk edge where d_valid=1.
- word  out  WIDTH  assembled word.
- word_valid  out  1  word holds an unconsumed word.
- word_ready  in  1  downstream accepts word on an edge where word_valid=1 and word_ready=1.
- overrun  out  1  sticky, set when an input bit is dropped.
- clear_ovr  in  1  synchronous clear of overrun.
- busy  out  1  high when bit count is nonzero or state is STALL.

Behaviour:
- Reset (rst=1, effective immediately without waiting for clk):
  - word=0, word_valid=0, overrun=0, busy=0.
  - Shift register=0, bit count=0, state=COLLECT.
- Reset asserted mid-frame discards the partial frame. The first d_valid after release starts a new frame at bit 0.
- States: COLLECT and STALL.
- COLLECT:
  - Each edge with d_valid=1 shifts d into the shift register; count increments.
  - Edges with d_valid=0 change nothing. Gaps between bits are allowed.
- Final bit (count=WIDTH-1 and d_valid=1):
  - If the buffer is free (word_valid=0) or draining this edge (word_valid=1 and word_ready=1): on that same edge, word <= assembled word including the final bit; word_valid=1; count=0; stay in COLLECT. Zero added latency: word_valid is high in the cycle after the final-bit edge.
  - Otherwise the assembled word is kept in the shift register; count=0; state goes to STALL.
- STALL:
  - d_valid bits are dropped; each dropped bit sets overrun=1.
  - On the edge where word_valid=1 and word_ready=1: word <= held word, word_valid stays 1, state returns to COLLECT.
  - The first bit of the next frame is accepted on the edge after that transfer.
- Handshake:
  - On a transfer edge with no replacement word, word_valid goes to 0.
  - word is stable while word_valid=1 and word_ready=0.
  - word keeps its last value after word_valid falls.
- overrun:
  - clear_ovr=1 clears overrun on the edge.
  - If a drop event and clear_ovr occur on the same edge, set wins.
- Bit ordering:
  - MSB_FIRST=1: shift left, new bit enters at the LSB.
  - MSB_FIRST=0: shift right, new bit enters at the MSB.
- Bit count register width is $clog2(WIDTH+1). Count never exceeds WIDTH-1 (WIDTH when parity is enabled) and wraps to 0 at frame end.

Optional Feature:
- Macro: DESER_PARITY_EN.
- Defined:
  - Each frame is WIDTH+1 bits; the last bit is an even-parity bit.
  - Extra output port parity_err (out, 1) is updated on the same edge as word. It is 1 when XOR of data bits and parity bit is 1.
  - parity_err is held or stalled together with word, and reset to 0.
  - The parity bit is not stored in word.
- Undefined: frames are WIDTH bits; the parity_err port does not exist.

Test Plan:
- WIDTH=8, MSB_FIRST=1, word_ready=1, contiguous bits 1,0,1,1,0,0,1,0 -> word=8'hB2. word_valid=1 for exactly one cycle, in the cycle after the 8th edge. overrun=0.
- MSB_FIRST=0, same bit sequence -> word=8'h4D.
- Same bits with d_valid=0 gaps of 1-3 cycles between bits -> word=8'hB2. busy=1 from the first bit until the frame completes.
- word_ready=0:
  - Send frames 8'hB2 then 8'h5A -> word=8'hB2 held, busy=1 (STALL).
  - Send 3 more bits -> overrun=1; those bits are lost.
  - Pulse word_ready one cycle -> word=8'h5A, word_valid=1.
  - Pulse clear_ovr -> overrun=0.
- Send 3 bits, assert rst between clk edges -> word=0, word_valid=0, busy=0 immediately. After release, frame 8'hB2 is received correctly.
- DESER_PARITY_EN defined:
  - 8'hB2 followed by parity bit 0 -> parity_err=0.
  - 8'hB2 followed by parity bit 1 -> parity_err=1. word=8'hB2 in both cases.
